// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_pkg
// Description : Shared definitions for the instruction sequencer: field widths,
//               opcode and ALU-op encodings, decoded-control bundle, FSM state
//               encoding and instruction-field extraction macros.
// Revision    : 1.0 - initial release
// ============================================================================

// Instruction word layout is {opcode, reg}; these pull the two fields apart.
`define INSTR_OPCODE(word, ow, rw) word[(ow)+(rw)-1 -: (ow)]
`define INSTR_REG(word, rw)        word[(rw)-1:0]

package instr_sequencer_pkg;

    localparam int OPCODE_W_DEF  = 3;
    localparam int REGADDR_W_DEF = 2;
    localparam int ADDR_W        = 5;
    localparam int ALUOP_W       = 2;

    // Opcode encodings
    localparam logic [2:0] c_OP_NOP = 3'd0;
    localparam logic [2:0] c_OP_LD  = 3'd1;
    localparam logic [2:0] c_OP_ST  = 3'd2;
    localparam logic [2:0] c_OP_ADD = 3'd3;
    localparam logic [2:0] c_OP_SUB = 3'd4;
    localparam logic [2:0] c_OP_XOR = 3'd5;

    // ALU operation encodings
    localparam logic [ALUOP_W-1:0] c_ALU_PASS = 2'd0;
    localparam logic [ALUOP_W-1:0] c_ALU_ADD  = 2'd1;
    localparam logic [ALUOP_W-1:0] c_ALU_SUB  = 2'd2;
    localparam logic [ALUOP_W-1:0] c_ALU_XOR  = 2'd3;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_EXEC   = 2'd3
    } state_e;

    // Decoded control bundle for one instruction
    typedef struct packed {
        logic               acc_we;
        logic               reg_we;
        logic [ALUOP_W-1:0] alu_op;
        logic               illegal;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/instr_sequencer_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode
// Description : Combinational opcode decoder. Maps an opcode to the datapath
//               strobes and ALU operation; undefined opcodes produce no
//               strobes and raise the illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
    import instr_sequencer_pkg::*;
#(
    parameter int OPCODE_W = OPCODE_W_DEF
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl
);

    localparam logic [OPCODE_W-1:0] c_NOP = OPCODE_W'(c_OP_NOP);
    localparam logic [OPCODE_W-1:0] c_LD  = OPCODE_W'(c_OP_LD);
    localparam logic [OPCODE_W-1:0] c_ST  = OPCODE_W'(c_OP_ST);
    localparam logic [OPCODE_W-1:0] c_ADD = OPCODE_W'(c_OP_ADD);
    localparam logic [OPCODE_W-1:0] c_SUB = OPCODE_W'(c_OP_SUB);
    localparam logic [OPCODE_W-1:0] c_XOR = OPCODE_W'(c_OP_XOR);

    // Opcode to control lookup; anything not listed is undefined
    always_comb begin
        ctrl         = '0;
        ctrl.alu_op  = c_ALU_PASS;
        case (opcode)
            c_NOP: ;
            c_LD: begin
                ctrl.acc_we = 1'b1;
                ctrl.alu_op = c_ALU_PASS;
            end
            c_ST: begin
                ctrl.reg_we = 1'b1;
            end
            c_ADD: begin
                ctrl.acc_we = 1'b1;
                ctrl.alu_op = c_ALU_ADD;
            end
            c_SUB: begin
                ctrl.acc_we = 1'b1;
                ctrl.alu_op = c_ALU_SUB;
            end
            c_XOR: begin
                ctrl.acc_we = 1'b1;
                ctrl.alu_op = c_ALU_XOR;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Fetch/decode/execute controller for the 32-entry instruction
//               ROM of the accumulator datapath. Owns the PC, latches the
//               instruction word and issues one-cycle control strobes.
//               Optional macro SINGLE_STEP_EN adds a 'step' input that gates
//               the EXEC -> FETCH transition.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int                OPCODE_W   = OPCODE_W_DEF,
    parameter int                REGADDR_W  = REGADDR_W_DEF,
    parameter logic [ADDR_W-1:0] START_ADDR = 5'd1,
    parameter logic [ADDR_W-1:0] END_ADDR   = 5'd31
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stop,
`ifdef SINGLE_STEP_EN
    input  logic                          step,
`endif
    input  logic [OPCODE_W+REGADDR_W-1:0] instr,
    output logic [ADDR_W-1:0]             rom_addr,
    output logic [REGADDR_W-1:0]          reg_sel,
    output logic [ALUOP_W-1:0]            alu_op,
    output logic                          acc_we,
    output logic                          reg_we,
    output logic                          busy,
    output logic                          done,
    output logic                          illegal
);

    localparam int c_IW = OPCODE_W + REGADDR_W;

    state_e                 r_state;
    logic [ADDR_W-1:0]      r_pc;
    logic [c_IW-1:0]        r_ir;
    logic [REGADDR_W-1:0]   r_reg_sel;
    logic [ALUOP_W-1:0]     r_alu_op;
    logic                   r_acc_we;
    logic                   r_reg_we;
    logic                   r_done;
    logic                   r_illegal;

    state_e                 w_state_nxt;
    logic [ADDR_W-1:0]      w_pc_nxt;
    logic [c_IW-1:0]        w_ir_nxt;
    logic [REGADDR_W-1:0]   w_reg_sel_nxt;
    logic [ALUOP_W-1:0]     w_alu_op_nxt;
    logic                   w_acc_we_nxt;
    logic                   w_reg_we_nxt;
    logic                   w_done_nxt;
    logic                   w_illegal_nxt;

    logic [OPCODE_W-1:0]    w_opcode;
    ctrl_t                  w_dec;
    logic                   w_advance;
    logic                   w_exit;

    assign w_opcode = `INSTR_OPCODE(r_ir, OPCODE_W, REGADDR_W);

    instr_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode (w_opcode),
        .ctrl   (w_dec)
    );

    // Permission to leave EXEC for the next instruction
`ifdef SINGLE_STEP_EN
    assign w_advance = step;
`else
    assign w_advance = 1'b1;
`endif

    // Leave the run after this EXEC: stop always wins, end of ROM only when advancing
    assign w_exit = stop | (w_advance & (r_pc == END_ADDR));

    // State register and all registered controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= START_ADDR;
            r_ir      <= '0;
            r_reg_sel <= '0;
            r_alu_op  <= '0;
            r_acc_we  <= 1'b0;
            r_reg_we  <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_ir      <= w_ir_nxt;
            r_reg_sel <= w_reg_sel_nxt;
            r_alu_op  <= w_alu_op_nxt;
            r_acc_we  <= w_acc_we_nxt;
            r_reg_we  <= w_reg_we_nxt;
            r_done    <= w_done_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    // Next-state and next-control logic; strobes and done default low
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_ir_nxt      = r_ir;
        w_reg_sel_nxt = r_reg_sel;
        w_alu_op_nxt  = r_alu_op;
        w_acc_we_nxt  = 1'b0;
        w_reg_we_nxt  = 1'b0;
        w_done_nxt    = 1'b0;
        w_illegal_nxt = r_illegal;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt   = ST_FETCH;
                    w_pc_nxt      = START_ADDR;
                    w_illegal_nxt = 1'b0;
                end
            end
            ST_FETCH: begin
                w_ir_nxt    = instr;
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                // Load controls now so they are stable for the whole EXEC cycle
                w_reg_sel_nxt = `INSTR_REG(r_ir, REGADDR_W);
                w_alu_op_nxt  = w_dec.alu_op;
                w_acc_we_nxt  = w_dec.acc_we;
                w_reg_we_nxt  = w_dec.reg_we;
                w_state_nxt   = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_dec.illegal) begin
                    w_illegal_nxt = 1'b1;
                end
                if (w_exit) begin
                    w_state_nxt = ST_IDLE;
                    w_pc_nxt    = START_ADDR;
                    w_done_nxt  = 1'b1;
                end else if (w_advance) begin
                    w_state_nxt = ST_FETCH;
                    w_pc_nxt    = r_pc + ADDR_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rom_addr = r_pc;
    assign reg_sel  = r_reg_sel;
    assign alu_op   = r_alu_op;
    assign acc_we   = r_acc_we;
    assign reg_we   = r_reg_we;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign illegal  = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Directed self-checking bench for instr_sequencer with a small
//               combinational ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       step;
    logic [4:0] instr;
    logic [4:0] rom_addr;
    logic [1:0] reg_sel;
    logic [1:0] alu_op;
    logic       acc_we;
    logic       reg_we;
    logic       busy;
    logic       done;
    logic       illegal;

    logic [4:0] rom [32];

    int total = 0;
    int bad   = 0;

    assign instr = rom[rom_addr];

    instr_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
`ifdef SINGLE_STEP_EN
        .step     (step),
`endif
        .instr    (instr),
        .rom_addr (rom_addr),
        .reg_sel  (reg_sel),
        .alu_op   (alu_op),
        .acc_we   (acc_we),
        .reg_we   (reg_we),
        .busy     (busy),
        .done     (done),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start; returns in the first FETCH cycle
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int busy_cnt;
    int done_cnt;
    int zero_cnt;
    int acc_cnt;
    int reg_cnt;

    initial begin
        // Program: 1 LD R3, 2 ST R2, 3 ADD R1, 4 SUB R3, 5 op7 R0, 6 XOR R2, rest NOP
        for (int i = 0; i < 32; i++) rom[i] = 5'b00000;
        rom[0] = {3'd1, 2'd0};
        rom[1] = {3'd1, 2'd3};
        rom[2] = {3'd2, 2'd2};
        rom[3] = {3'd3, 2'd1};
        rom[4] = {3'd4, 2'd3};
        rom[5] = {3'd7, 2'd0};
        rom[6] = {3'd5, 2'd2};

        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        step  = 1'b1;
        tick();
        tick();
        check("rst_addr",   rom_addr, 5'd1);
        check("rst_busy",   busy,     1'b0);
        check("rst_strobe", {acc_we, reg_we, done, illegal}, 4'b0000);
        check("rst_ctrl",   {reg_sel, alu_op}, 4'b0000);
        rst_n = 1'b1;
        tick();

        // ---- Run 1: LD R3, ST R2, ADD R1 (start pulses ignored), SUB R3 with stop
        do_start();                              // FETCH addr1
        check("r1_fetch_busy", busy, 1'b1);
        check("r1_fetch_addr", rom_addr, 5'd1);
        check("r1_fetch_acc",  acc_we, 1'b0);
        tick();                                  // DECODE
        check("r1_dec_acc", acc_we, 1'b0);
        tick();                                  // EXEC addr1
        check("r1_ld_acc",  acc_we, 1'b1);
        check("r1_ld_reg",  reg_we, 1'b0);
        check("r1_ld_op",   alu_op, 2'd0);
        check("r1_ld_sel",  reg_sel, 2'd3);
        tick();                                  // FETCH addr2
        check("r1_addr2",   rom_addr, 5'd2);
        check("r1_acc_off", acc_we, 1'b0);
        check("r1_sel_hold", reg_sel, 2'd3);
        tick();
        tick();                                  // EXEC addr2
        check("r1_st_reg",  reg_we, 1'b1);
        check("r1_st_acc",  acc_we, 1'b0);
        check("r1_st_sel",  reg_sel, 2'd2);
        start = 1'b1;                            // start while busy
        tick();                                  // FETCH addr3
        start = 1'b0;
        check("r1_addr3", rom_addr, 5'd3);
        tick();
        tick();                                  // EXEC addr3
        check("r1_add", {acc_we, reg_we, alu_op, reg_sel}, {1'b1, 1'b0, 2'd1, 2'd1});
        check("r1_add_addr", rom_addr, 5'd3);
        tick();                                  // FETCH addr4
        check("r1_addr4", rom_addr, 5'd4);
        tick();                                  // DECODE addr4
        stop = 1'b1;
        tick();                                  // EXEC addr4
        check("r1_sub", {acc_we, reg_we, alu_op, reg_sel}, {1'b1, 1'b0, 2'd2, 2'd3});
        check("r1_sub_done", done, 1'b0);
        tick();                                  // IDLE
        stop = 1'b0;
        check("r1_done",      done, 1'b1);
        check("r1_idle_busy", busy, 1'b0);
        check("r1_idle_addr", rom_addr, 5'd1);
        check("r1_idle_acc",  acc_we, 1'b0);
        tick();
        check("r1_done_pulse", done, 1'b0);

        // ---- Run 2: illegal opcode at addr5, next instruction normal
        do_start();
        for (int i = 0; i < 14; i++) tick();    // EXEC addr5
        check("r2_ill_addr",   rom_addr, 5'd5);
        check("r2_ill_strobe", {acc_we, reg_we}, 2'b00);
        tick();                                  // FETCH addr6
        check("r2_ill_set", illegal, 1'b1);
        tick();
        tick();                                  // EXEC addr6
        check("r2_xor", {acc_we, reg_we, alu_op, reg_sel}, {1'b1, 1'b0, 2'd3, 2'd2});
        check("r2_ill_sticky", illegal, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("r2_done",       done, 1'b1);
        check("r2_ill_idle",   illegal, 1'b1);
        tick();

        // ---- Run 3: full program 1..31
        do_start();
        check("r3_ill_clear", illegal, 1'b0);
        busy_cnt = 0;
        done_cnt = 0;
        zero_cnt = 0;
        acc_cnt  = 0;
        reg_cnt  = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy) begin
                busy_cnt++;
                if (rom_addr == 5'd0) zero_cnt++;
            end
            if (done)   done_cnt++;
            if (acc_we) acc_cnt++;
            if (reg_we) reg_cnt++;
            tick();
        end
        check("r3_busy_cycles", busy_cnt, 93);
        check("r3_done_count",  done_cnt, 1);
        check("r3_addr0_seen",  zero_cnt, 0);
        check("r3_acc_count",   acc_cnt, 4);
        check("r3_reg_count",   reg_cnt, 1);
        check("r3_end_addr",    rom_addr, 5'd1);
        check("r3_end_busy",    busy, 1'b0);
        check("r3_ill",         illegal, 1'b1);

        // ---- Run 4: start with stop held runs one instruction
        stop = 1'b1;
        do_start();
        tick();
        tick();                                  // EXEC addr1
        check("r4_ld", {acc_we, reg_sel}, {1'b1, 2'd3});
        tick();
        check("r4_done", {done, busy, rom_addr}, {1'b1, 1'b0, 5'd1});
        stop = 1'b0;
        tick();

        // ---- Run 5: asynchronous reset in the middle of EXEC
        do_start();
        tick();
        tick();                                  // EXEC addr1
        check("r5_pre_acc", acc_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("r5_rst_strobe", {acc_we, reg_we, done, illegal}, 4'b0000);
        check("r5_rst_ctrl",   {reg_sel, alu_op}, 4'b0000);
        check("r5_rst_busy",   busy, 1'b0);
        check("r5_rst_addr",   rom_addr, 5'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("r5_post_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
